// File: rtl/regfile_pkg.sv
// Shared types for the register file write-back path.
// Result bundle carried from ALU/LSU to the write port.
package regfile_pkg;
   localparam int XLEN      = 32;
   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests.
// Depth is a power of two; pointers carry one wrap bit.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    full,
   output logic    empty
);
   localparam int AW = $clog2(DEPTH);

   wb_req_t      mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   // next pointer values, wrapping through the extra bit
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   // pointer registers, emptied by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // storage array; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and buffered LSU results onto the single
// register file write port and tracks busy registers.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LSU_DEPTH    = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rf_write,
   output logic [4:0]      rf_writenum,
   output logic [XLEN-1:0] rf_write_data
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   wb_req_t         lsu_req, alu_req, head, win;
   logic            f_full, f_empty;
   logic            block, alu_fire, pop;
   logic [SW-1:0]   starve_q, starve_d;
   logic [31:0]     busy_q, busy_d;
   logic            wr_q, wr_d;
   logic [4:0]      num_q, num_d;
   logic [XLEN-1:0] data_q, data_d;

   assign lsu_req = '{rd: lsu_rd, data: lsu_data};
   assign alu_req = '{rd: alu_rd, data: alu_data};

   wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (lsu_valid),
      .pop   (pop),
      .din   (lsu_req),
      .dout  (head),
      .full  (f_full),
      .empty (f_empty)
   );

   assign lsu_ready = !f_full;
   assign block     = (starve_q == LIMIT) && !f_empty;
   assign alu_ready = !block;
   assign alu_fire  = alu_valid && alu_ready;
   assign pop       = !alu_fire && !f_empty;
   assign win       = alu_fire ? alu_req : head;

   assign rs1_busy      = (rs1 != 5'd0) && busy_q[rs1];
   assign rs2_busy      = (rs2 != 5'd0) && busy_q[rs2];
   assign rf_write      = wr_q;
   assign rf_writenum   = num_q;
   assign rf_write_data = data_q;

   // pick the winner, update starvation and busy bits
   always_comb begin
      wr_d     = (alu_fire || pop) && (win.rd != 5'd0);
      num_d    = wr_d ? win.rd : num_q;
      data_d   = wr_d ? win.data : data_q;
      starve_d = starve_q;
      if (f_empty || pop)
         starve_d = '0;
      else if (alu_fire && starve_q != LIMIT)
         starve_d = starve_q + 1'b1;
      busy_d = busy_q;
      if (wr_q)
         busy_d[num_q] = 1'b0;
      if (issue_valid && issue_rd != 5'd0)
         busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // state and registered write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q     <= 1'b0;
         num_q    <= '0;
         data_q   <= '0;
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         wr_q     <= wr_d;
         num_q    <= num_d;
         data_q   <= data_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench for regfile_wb_arbiter.
// A queue-based reference model predicts every write.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int LSU_DEPTH    = 4;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0, alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        lsu_valid = 1'b0, lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [4:0]  rs1 = '0, rs2 = '0;
   logic        rs1_busy, rs2_busy;
   logic        rf_write;
   logic [4:0]  rf_writenum;
   logic [31:0] rf_write_data;

   regfile_wb_arbiter #(
      .XLEN(32), .LSU_DEPTH(LSU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1(rs1), .rs2(rs2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rf_write(rf_write), .rf_writenum(rf_writenum),
      .rf_write_data(rf_write_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   // reference model state
   wb_req_t     lsu_m[$];
   wb_req_t     exp_q[$];
   int          starve_m = 0;
   logic [31:0] busy_m = '0;
   bit          pend_v = 1'b0;
   logic [4:0]  pend_rd = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, req, $time);
      end
   endtask

   // monitor: every cycle either an expected write or none
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            wb_req_t w;
            w = exp_q.pop_front();
            chk("rf_write", 64'(rf_write), 64'd1);
            chk("rf_writenum", 64'(rf_writenum), 64'(w.rd));
            chk("rf_write_data", 64'(rf_write_data), 64'(w.data));
         end else begin
            chk("rf_write_idle", 64'(rf_write), 64'd0);
         end
      end
   end

   // one clock of stimulus; called at posedge+1
   task automatic cyc(input bit av, input logic [4:0] ard,
                      input logic [31:0] ad, input bit lv,
                      input logic [4:0] lrd, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input bit rst = 1'b1);
      bit mar, mlr, fire, pop, nonempty;
      wb_req_t w;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      issue_valid = iv; issue_rd = ird;
      rs1 = r1; rs2 = r2; rst_n = rst;
      nonempty = lsu_m.size() > 0;
      mar = !(starve_m == STARVE_LIMIT && nonempty);
      mlr = lsu_m.size() < LSU_DEPTH;
      #1;
      if (rst) begin
         chk("alu_ready", 64'(alu_ready), 64'(mar));
         chk("lsu_ready", 64'(lsu_ready), 64'(mlr));
         chk("rs1_busy", 64'(rs1_busy), 64'(r1 != 0 && busy_m[r1]));
         chk("rs2_busy", 64'(rs2_busy), 64'(r2 != 0 && busy_m[r2]));
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         lsu_m.delete();
         starve_m = 0;
         busy_m = '0;
         pend_v = 1'b0;
      end else begin
         fire = av && mar;
         pop = !fire && nonempty;
         if (pend_v) busy_m[pend_rd] = 1'b0;
         if (iv && ird != 0) busy_m[ird] = 1'b1;
         w = '{rd: ard, data: ad};
         if (pop) w = lsu_m.pop_front();
         pend_v = (fire || pop) && w.rd != 0;
         pend_rd = w.rd;
         if (pend_v) exp_q.push_back(w);
         if (!nonempty || pop) starve_m = 0;
         else if (fire && starve_m < STARVE_LIMIT) starve_m++;
         if (lv && mlr) lsu_m.push_back('{rd: lrd, data: ld});
      end
   endtask

   task automatic idle(input logic [4:0] r1 = 5'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      mon_en = 1'b1;
      chk("reset_writenum", 64'(rf_writenum), 64'd0);
      chk("reset_data", 64'(rf_write_data), 64'd0);
      chk("reset_write", 64'(rf_write), 64'd0);

      // single ALU write, then rd=0 discard
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle();
      cyc(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle();

      // fill FIFO while ALU is continuously valid
      for (int i = 1; i <= 4; i++)
         cyc(1, 5'(16 + i), $urandom, 1, 5'(i), $urandom, 0, 0, 0, 0);
      chk("fill_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("fill_alu_block", 64'(alu_ready), 64'd0);
      for (int i = 0; i < 16; i++)
         cyc(1, 5'(21 + i % 8), $urandom, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle();

      // scoreboard set/clear, then set winning over clear
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(7);
      cyc(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
      idle(7); idle(7); idle(7);
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      cyc(0, 0, 0, 1, 7, 32'h78, 0, 0, 7, 0);
      idle(7);
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(7);
      chk("busy7_set_wins", 64'(rs1_busy), 64'd1);
      idle(7);

      // reset with a partly full FIFO and a busy register
      cyc(1, 12, 32'hA, 1, 3, 32'hB, 1, 3, 3, 0);
      cyc(1, 13, 32'hC, 1, 4, 32'hD, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1'b0);
      rs1 = 5'd3;
      #1;
      chk("rst_busy3", 64'(rs1_busy), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
      chk("rst_rf_write", 64'(rf_write), 64'd0);
      idle(3); idle(3);

      // simultaneous sources with empty FIFO
      cyc(1, 2, 32'h22, 1, 9, 32'h99, 0, 0, 0, 0);
      idle(); idle(); idle();

      // randomised traffic with occasional resets
      for (int n = 0; n < 800; n++) begin
         cyc($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
             $urandom, $urandom_range(0, 9) < 5,
             5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 99) != 0);
      end
      for (int n = 0; n < 8; n++) idle();
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("exp_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
